// File: rtl/kf_frame_sequencer_pkg.sv
// Shared fixed-point defaults, latency contract and sequencer state encoding
// for the Kalman-filter frame sequencer.
package kf_frame_sequencer_pkg;

    localparam int FXP_N      = 32;
    localparam int FXP_FRAC   = 16;
    localparam int KF_LAT     = 36;
    localparam int KF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/kf_lat_watchdog.sv
// Counts cycles spent waiting on the core; flags the contracted done slot
// (LAT-1) and the abort slot (TIMEOUT-1).
module kf_lat_watchdog
    import kf_frame_sequencer_pkg::*;
#(
    parameter int LAT     = KF_LAT,
    parameter int TIMEOUT = KF_TIMEOUT,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic on_time,
    output logic timeout
);

    logic [CNT_W-1:0] cnt;

    // The sequencer leaves WAIT at TIMEOUT-1 at the latest, so cnt never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + CNT_W'(1);
    end

    assign on_time = (cnt == CNT_W'(LAT - 1));
    assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/kf_frame_sequencer.sv
// Initiator for the Kalman core start/done handshake: one kf_start per accepted
// frame, posterior fed back as next x_prev, latency contract policed.
module kf_frame_sequencer
    import kf_frame_sequencer_pkg::*;
#(
    parameter int N       = FXP_N,
    parameter int FRAC    = FXP_FRAC,
    parameter int LAT     = KF_LAT,
    parameter int TIMEOUT = KF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic signed [N-1:0] x00_init,
    input  logic signed [N-1:0] x10_init,
    input  logic                meas_valid,
    output logic                meas_ready,
    input  logic signed [N-1:0] z00_in,
    input  logic signed [N-1:0] z10_in,
    input  logic signed [N-1:0] u00_in,
    input  logic signed [N-1:0] u10_in,
    output logic                kf_start,
    output logic signed [N-1:0] kf_x00_prev,
    output logic signed [N-1:0] kf_x10_prev,
    output logic signed [N-1:0] kf_z00,
    output logic signed [N-1:0] kf_z10,
    output logic signed [N-1:0] kf_u00,
    output logic signed [N-1:0] kf_u10,
    input  logic                kf_done,
    input  logic signed [N-1:0] kf_X00_post,
    input  logic signed [N-1:0] kf_X10_post,
    output logic                est_valid,
    output logic signed [N-1:0] est_x00,
    output logic signed [N-1:0] est_x10,
    output logic                busy,
    output logic [15:0]         frame_cnt,
    output logic                err_timeout,
    output logic                err_latency,
    input  logic                clr_err
);

    // A misconfigured instance never accepts a frame, so the fault is visible at the first handshake.
    localparam logic CFG_OK = (FRAC < N) && (TIMEOUT > LAT) && (LAT > 0);

    seq_state_t state;
    logic       ready_en;
    logic       wd_on_time;
    logic       wd_timeout;
    logic       lat_err_set;
    logic       timeout_set;

    kf_lat_watchdog #(
        .LAT     (LAT),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == ST_ISSUE),
        .enable  (state == ST_WAIT),
        .on_time (wd_on_time),
        .timeout (wd_timeout)
    );

    assign meas_ready  = ready_en && CFG_OK && (state == ST_IDLE) && !init;
    assign busy        = (state != ST_IDLE);
    // A done pulse is only legal in WAIT at the contracted slot.
    assign lat_err_set = kf_done && ((state != ST_WAIT) || !wd_on_time);
    assign timeout_set = (state == ST_WAIT) && wd_timeout && !kf_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ready_en    <= 1'b0;
            kf_start    <= 1'b0;
            est_valid   <= 1'b0;
            kf_x00_prev <= '0;
            kf_x10_prev <= '0;
            kf_z00      <= '0;
            kf_z10      <= '0;
            kf_u00      <= '0;
            kf_u10      <= '0;
            est_x00     <= '0;
            est_x10     <= '0;
            frame_cnt   <= '0;
            err_timeout <= 1'b0;
            err_latency <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            kf_start  <= 1'b0;
            est_valid <= 1'b0;

            if (lat_err_set)
                err_latency <= 1'b1;
            else if (clr_err)
                err_latency <= 1'b0;

            if (timeout_set)
                err_timeout <= 1'b1;
            else if (clr_err)
                err_timeout <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (init) begin
                        kf_x00_prev <= x00_init;
                        kf_x10_prev <= x10_init;
                        est_x00     <= x00_init;
                        est_x10     <= x10_init;
                    end else if (meas_valid && meas_ready) begin
                        kf_z00   <= z00_in;
                        kf_z10   <= z10_in;
                        kf_u00   <= u00_in;
                        kf_u10   <= u10_in;
                        kf_start <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (kf_done) begin
                        kf_x00_prev <= kf_X00_post;
                        kf_x10_prev <= kf_X10_post;
                        est_x00     <= kf_X00_post;
                        est_x10     <= kf_X10_post;
                        frame_cnt   <= frame_cnt + 16'd1;
                        est_valid   <= 1'b1;
                        state       <= ST_OUT;
                    end else if (wd_timeout) begin
                        state <= ST_IDLE;
                    end
                end
                ST_OUT: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
